// File: rtl/test_cell_pkg.sv
// Shared types, default cell patterns and the operand masking helper for the
// test_cell round-robin scheduler.
package test_cell_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  localparam logic [5:0] PAT_CELL_DEFAULT = 6'b100111;
  localparam logic [5:0] PAT_O1_DEFAULT   = 6'b110011;

  // The shift keeps the whole operand in the expression, so the result is i1[3:2] & i2.
  function automatic logic [1:0] mask_term(input logic [3:0] i1, input logic [1:0] i2);
    return 2'(i1 >> 2) & i2;
  endfunction

endpackage

// File: rtl/test_cell_sched_rr_arbiter.sv
// Round-robin arbiter: scans requests from i_ptr upward with wrap-around and
// returns a one-hot grant plus the granted index while enabled.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  always_comb begin
    logic [IDW-1:0] w_j;
    logic           w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_j = IDW'((32'(i_ptr) + i) % NUM_REQ);
      if (i_en && !w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        w_found      = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/test_cell_sched.sv
// Shares one test_cell between NUM_REQ requesters: grants round-robin, holds the
// masked cell input for CELL_LATENCY cycles, then returns the captured output.
module test_cell_sched
  import test_cell_pkg::*;
#(
  parameter  int         NUM_REQ      = 2,
  parameter  int         CELL_LATENCY = 2,
  parameter  logic [5:0] PAT_CELL     = PAT_CELL_DEFAULT,
  parameter  logic [5:0] PAT_O1       = PAT_O1_DEFAULT,
  localparam int         IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_i1,
  input  logic [2*NUM_REQ-1:0] req_i2,
  output logic [7:0]           cell_in,
  input  logic [7:0]           cell_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [7:0]           resp_data,
  output logic [7:0]           resp_o1,
  output logic                 busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("test_cell_sched: NUM_REQ must be in 2..8");
  end
  if (CELL_LATENCY < 1 || CELL_LATENCY > 15) begin : g_bad_latency
    $error("test_cell_sched: CELL_LATENCY must be in 1..15");
  end

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [3:0]       r_cnt;
  logic [7:0]       r_cell_in;
  logic             r_resp_valid;
  logic [IDW-1:0]   r_resp_id;
  logic [7:0]       r_resp_data;
  logic [7:0]       r_resp_o1;
  logic             r_busy;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic [3:0]         w_i1;
  logic [1:0]         w_i2;
  logic [1:0]         w_internal;
  logic [IDW-1:0]     w_next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (r_state == IDLE),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_i1       = req_i1[{w_idx, 2'b00} +: 4];
  assign w_i2       = req_i2[{w_idx, 1'b0} +: 2];
  assign w_internal = mask_term(w_i1, w_i2);
  assign w_next_ptr = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_cell_in    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_o1    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cell_in <= {w_internal, PAT_CELL};
            r_resp_o1 <= {w_internal, PAT_O1};
            r_resp_id <= w_idx;
            r_ptr     <= w_next_ptr;
            r_cnt     <= 4'(CELL_LATENCY - 1);
            r_busy    <= 1'b1;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            r_resp_data  <= cell_out;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign cell_in    = r_cell_in;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_o1    = r_resp_o1;
  assign busy       = r_busy;

endmodule

// File: tb/tb_test_cell_sched.sv
// Directed bench for test_cell_sched: a 2-requester/latency-2 instance and a
// 3-requester/latency-1 instance, each driven by an inverting cell model.
module tb_test_cell_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Instance A: NUM_REQ=2, CELL_LATENCY=2
  logic       a_rst;
  logic [1:0] a_req_valid, a_req_ready;
  logic [7:0] a_req_i1;
  logic [3:0] a_req_i2;
  logic [7:0] a_cell_in, a_cell_out, a_resp_data, a_resp_o1;
  logic       a_resp_valid, a_resp_ready, a_busy;
  logic [0:0] a_resp_id;

  assign a_cell_out = ~a_cell_in;

  test_cell_sched #(.NUM_REQ(2), .CELL_LATENCY(2)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_i1(a_req_i1), .req_i2(a_req_i2),
    .cell_in(a_cell_in), .cell_out(a_cell_out),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_id(a_resp_id), .resp_data(a_resp_data), .resp_o1(a_resp_o1),
    .busy(a_busy)
  );

  // Instance B: NUM_REQ=3, CELL_LATENCY=1
  logic        b_rst;
  logic [2:0]  b_req_valid, b_req_ready;
  logic [11:0] b_req_i1;
  logic [5:0]  b_req_i2;
  logic [7:0]  b_cell_in, b_cell_out, b_resp_data, b_resp_o1;
  logic        b_resp_valid, b_resp_ready, b_busy;
  logic [1:0]  b_resp_id;

  assign b_cell_out = ~b_cell_in;

  test_cell_sched #(.NUM_REQ(3), .CELL_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_i1(b_req_i1), .req_i2(b_req_i2),
    .cell_in(b_cell_in), .cell_out(b_cell_out),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_id(b_resp_id), .resp_data(b_resp_data), .resp_o1(b_resp_o1),
    .busy(b_busy)
  );

  task automatic wait_grant_a();
    #1;
    for (int k = 0; k < 10 && a_req_ready == '0; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_resp_a();
    for (int k = 0; k < 10 && !a_resp_valid; k++) @(negedge clk);
  endtask

  // Expected per-requester results for instance A in the round-robin phase:
  // req0 internal=01 -> cell_in 0x67, req1 internal=10 -> cell_in 0xA7.
  logic [7:0] exp_data [2] = '{8'h98, 8'h58};
  logic [7:0] exp_o1   [2] = '{8'h73, 8'hB3};

  initial begin
    logic [1:0]  exp_grant;
    int unsigned last_grant_cyc;
    int          seen_valid;

    a_rst = 1'b1; a_req_valid = '0; a_req_i1 = '0; a_req_i2 = '0; a_resp_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = '0; b_req_i1 = '0; b_req_i2 = '0; b_resp_ready = 1'b0;
    last_grant_cyc = 0;
    seen_valid     = 0;

    // Reset / idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cell_in",    a_cell_in,    8'h00);
    check("rst_resp_valid", a_resp_valid, 1'b0);
    check("rst_busy",       a_busy,       1'b0);
    check("rst_req_ready",  a_req_ready,  2'b00);
    check("rst_resp_data",  a_resp_data,  8'h00);
    check("rst_resp_o1",    a_resp_o1,    8'h00);
    check("rst_resp_id",    a_resp_id,    1'b0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Single request from requester 0: i1=1100, i2=10 -> internal 10
    a_req_valid = 2'b01; a_req_i1 = 8'h0C; a_req_i2 = 4'b0010;
    #1 check("single_grant", a_req_ready, 2'b01);
    @(negedge clk);
    check("single_cell_in_t1", a_cell_in,    8'hA7);
    check("single_busy_t1",    a_busy,       1'b1);
    check("single_ready_t1",   a_req_ready,  2'b00);
    check("single_valid_t1",   a_resp_valid, 1'b0);
    a_req_valid = 2'b00;
    @(negedge clk);
    check("single_valid_t2",   a_resp_valid, 1'b0);
    @(negedge clk);
    check("single_valid_t3",   a_resp_valid, 1'b1);
    check("single_data",       a_resp_data,  8'h58);
    check("single_o1",         a_resp_o1,    8'hB3);
    check("single_id",         a_resp_id,    1'b0);
    a_resp_ready = 1'b1;
    @(negedge clk);
    check("single_valid_done", a_resp_valid, 1'b0);
    check("single_busy_done",  a_busy,       1'b0);
    check("single_cell_kept",  a_cell_in,    8'hA7);
    a_resp_ready = 1'b0;

    // Round robin with both requesters continuously valid
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_req_i1 = {4'b1000, 4'b1111};
    a_req_i2 = {2'b11, 2'b01};
    a_req_valid = 2'b11;
    a_resp_ready = 1'b1;
    exp_grant = 2'b01;
    for (int op = 0; op < 4; op++) begin
      wait_grant_a();
      check($sformatf("rr_grant_%0d", op), a_req_ready, exp_grant);
      if (op > 0) check($sformatf("rr_interval_%0d", op), cyc - last_grant_cyc, 4);
      last_grant_cyc = cyc;
      @(negedge clk);
      wait_resp_a();
      check($sformatf("rr_valid_%0d", op), a_resp_valid, 1'b1);
      check($sformatf("rr_id_%0d", op),    a_resp_id,    exp_grant[1]);
      check($sformatf("rr_data_%0d", op),  a_resp_data,  exp_data[exp_grant[1]]);
      check($sformatf("rr_o1_%0d", op),    a_resp_o1,    exp_o1[exp_grant[1]]);
      exp_grant = ~exp_grant;
    end

    // Back-pressure: the fifth grant (requester 0) then resp_ready low for 5 cycles
    wait_grant_a();
    check("bp_grant",    a_req_ready, 2'b01);
    check("bp_interval", cyc - last_grant_cyc, 4);
    a_resp_ready = 1'b0;
    a_req_valid  = 2'b01;
    @(negedge clk);
    wait_resp_a();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid_%0d", k), a_resp_valid, 1'b1);
      check($sformatf("bp_data_%0d", k),  a_resp_data,  8'h98);
      check($sformatf("bp_ready_%0d", k), a_req_ready,  2'b00);
      @(negedge clk);
    end
    a_resp_ready = 1'b1;
    #1 check("bp_no_bypass", a_req_ready, 2'b00);
    @(negedge clk);
    a_resp_ready = 1'b0;
    check("bp_valid_done",   a_resp_valid, 1'b0);
    check("bp_grant_after",  a_req_ready,  2'b01);

    // Reset mid-DRIVE: rr_ptr is 1 here, reset must return it to 0
    @(negedge clk);
    a_req_valid = 2'b00;
    check("abort_cell_in_t1", a_cell_in, 8'h67);
    a_rst = 1'b1;
    @(negedge clk);
    check("abort_busy",    a_busy,       1'b0);
    check("abort_cell_in", a_cell_in,    8'h00);
    check("abort_valid",   a_resp_valid, 1'b0);
    a_rst = 1'b0;
    a_resp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (a_resp_valid || a_busy) seen_valid++;
    end
    check("abort_no_resp", seen_valid, 0);
    a_req_valid = 2'b11;
    #1 check("abort_ptr_reset", a_req_ready, 2'b01);
    @(negedge clk);
    a_req_valid = 2'b00;
    wait_resp_a();
    check("abort_next_data", a_resp_data, 8'h98);
    check("abort_next_id",   a_resp_id,   1'b0);
    @(negedge clk);

    // Instance B: requester 2 (internal 01), then requester 0 (internal 11)
    b_req_i1 = {4'b0110, 4'b0000, 4'b1100};
    b_req_i2 = {2'b11, 2'b00, 2'b11};
    b_req_valid = 3'b100;
    #1 check("w_grant_2", b_req_ready, 3'b100);
    @(negedge clk);
    b_req_valid = 3'b000;
    check("w_cell_in_2", b_cell_in,    8'h67);
    check("w_valid_t1",  b_resp_valid, 1'b0);
    @(negedge clk);
    check("w_valid_t2",  b_resp_valid, 1'b1);
    check("w_id_2",      b_resp_id,    2'd2);
    check("w_data_2",    b_resp_data,  8'h98);
    check("w_o1_2",      b_resp_o1,    8'h73);
    b_resp_ready = 1'b1;
    @(negedge clk);
    check("w_valid_done", b_resp_valid, 1'b0);
    b_resp_ready = 1'b0;
    b_req_valid  = 3'b001;
    #1 check("w_grant_0", b_req_ready, 3'b001);
    @(negedge clk);
    b_req_valid = 3'b000;
    check("w_cell_in_0",  b_cell_in,    8'hE7);
    check("w_valid0_t1",  b_resp_valid, 1'b0);
    @(negedge clk);
    check("w_valid0_t2",  b_resp_valid, 1'b1);
    check("w_id_0",       b_resp_id,    2'd0);
    check("w_data_0",     b_resp_data,  8'h18);
    check("w_o1_0",       b_resp_o1,    8'hF3);
    b_resp_ready = 1'b1;
    @(negedge clk);
    check("w_valid0_done", b_resp_valid, 1'b0);
    b_resp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
